demux_l2_unbundle: RTL
======================

// Module: demux_l2_unbundle
// PURPOSE
//  Single-clock stage directly downstream of the level-2 4:1 mux tree.
//  Takes the serialized byte stream (valid/data on cclk) and rebuilds 4 parallel lanes.
//  Word k of each group of 4 goes to lane k.
//  A complete group is presented on all four lanes in one cycle.
//  Incomplete groups are flushed on request or on an idle timeout.
// PARAMETERS
//  DATA_W   8  width of data_in and of each data_outN
//  TIMEOUT  8  idle cycles (valid_in low) mid-group before an automatic partial flush; legal range 1..255
// PORTS
//  cclk        in   1       clock; all logic on rising edge
//  reset       in   1       asynchronous, active-high reset
//  valid_in    in   1       data_in holds a valid word this cycle
//  data_in     in   DATA_W  serialized word from the level-2 mux
//  flush       in   1       present the current partial group now
//  valid_out0  out  1       lane 0 word valid (1-cycle pulse)
//  valid_out1  out  1       lane 1 word valid
//  valid_out2  out  1       lane 2 word valid
//  valid_out3  out  1       lane 3 word valid
//  data_out0   out  DATA_W  lane 0 word
//  data_out1   out  DATA_W  lane 1 word
//  data_out2   out  DATA_W  lane 2 word
//  data_out3   out  DATA_W  lane 3 word
//  partial     out  1       high with the valid_outN pulse when the presented group has <4 words
//  group_cnt   out  8       number of groups presented (full or partial); wraps 255->0
// BEHAVIOUR
//  Reset (async):
//   - all valid_outN, data_outN, partial, group_cnt = 0
//   - lane pointer ptr = 0, slot buffer cleared, idle counter = 0
//  Fill:
//   - on valid_in: slot[ptr] <= data_in, ptr <= ptr+1 (2-bit, wraps 3->0)
//  Full group (valid_in with ptr==3):
//   - next cycle: data_outN = slot[N] (with the 4th word in lane 3)
//   - valid_out0..3 = 1 for exactly one cycle; partial = 0
//   - latency: 1 cycle from the 4th word
//   - back-to-back groups are accepted with no bubble; valid_in is never refused
//  Flush (flush=1 and ptr!=0, or ptr!=0 after TIMEOUT idle cycles):
//   - next cycle: valid_outN = 1 only for lanes 0..ptr-1; partial = 1
//   - data_outN of unfilled lanes = 0
//   - ptr <= 0
//  flush with valid_in in the same cycle:
//   - the incoming word is written first, then included in the flushed group
//   - if that word is the 4th, the group is a full group and partial = 0
//  flush with ptr==0 and no valid_in: no effect, no pulse
//  Idle counter:
//   - cleared on valid_in or when ptr==0
//   - otherwise increments; a flush fires when it reaches TIMEOUT
//  Outputs are registered:
//   - data_outN hold their last value between pulses
//   - valid_outN and partial are low outside pulse cycles
//  group_cnt increments in the pulse cycle
//  Reset mid-group: the partial group is discarded silently; no pulse after reset release
// TESTING
//  1. Reset, then data_in 0x11,0x22,0x33,0x44 on 4 consecutive cycles
//     -> 1 cycle later: data_out0..3 = 11,22,33,44; all valid_out high for 1 cycle; partial=0; group_cnt=1
//  2. 8 back-to-back words 0x01..0x08
//     -> two pulses 4 cycles apart; lanes = 01..04 then 05..08; group_cnt=2
//  3. 0xA1,0xA2, then flush=1
//     -> next cycle: valid_out0,1 = 1; valid_out2,3 = 0; data_out0,1 = A1,A2; data_out2,3 = 0; partial=1
//  4. 0xB1, then valid_in low for TIMEOUT(8) cycles
//     -> auto flush: only valid_out0 pulses, data_out0 = B1, partial=1
//     -> the next word lands in lane 0
//  5. 0xC1,0xC2,0xC3, then 0xC4 together with flush=1
//     -> full group C1..C4; partial=0; exactly one pulse
//  6. 0xD1,0xD2, assert reset, release, then 0xE1..0xE4
//     -> no pulse for D*; group E1..E4 presented correctly; group_cnt=1

Source files
------------

// File: rtl/demux_l2_unbundle.sv
// Rebuilds four parallel lanes from the serialized level-2 byte stream; word k of a group goes to lane k.
// Latency 1 cycle from the completing word or flush; input is never refused, back-to-back groups need no bubble.
module demux_l2_unbundle #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 8
) (
    input  logic              cclk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              flush,
    output logic              valid_out0,
    output logic              valid_out1,
    output logic              valid_out2,
    output logic              valid_out3,
    output logic [DATA_W-1:0] data_out0,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    output logic [DATA_W-1:0] data_out3,
    output logic              partial,
    output logic [7:0]        group_cnt
);

    localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

    logic [1:0]        r_ptr;
    logic [DATA_W-1:0] r_slot [0:3];
    logic [7:0]        r_idle;
    logic [3:0]        r_vld;
    logic [DATA_W-1:0] r_dout [0:3];
    logic              r_partial;
    logic [7:0]        r_gcnt;

    logic [2:0]        w_cnt;
    logic              w_timeout;
    logic              w_fire;
    logic [DATA_W-1:0] w_slot_nxt [0:3];

    // Word count including the one arriving this cycle (0..4).
    assign w_cnt     = {1'b0, r_ptr} + {2'b00, valid_in};
    assign w_timeout = !valid_in && (r_ptr != 2'd0) && (r_idle == TO_M1);
    assign w_fire    = (w_cnt == 3'd4) || ((flush || w_timeout) && (w_cnt != 3'd0));

    // The incoming word is written before the group is presented, so a same-cycle flush includes it.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_slot_nxt[k] = r_slot[k];
        end
        if (valid_in) begin
            w_slot_nxt[r_ptr] = data_in;
        end
    end

    always_ff @(posedge cclk or posedge reset) begin
        if (reset) begin
            r_ptr     <= 2'd0;
            r_idle    <= 8'd0;
            r_vld     <= 4'd0;
            r_partial <= 1'b0;
            r_gcnt    <= 8'd0;
            for (int k = 0; k < 4; k++) begin
                r_slot[k] <= '0;
                r_dout[k] <= '0;
            end
        end else begin
            r_ptr <= w_fire ? 2'd0 : w_cnt[1:0];
            for (int k = 0; k < 4; k++) begin
                r_slot[k] <= w_slot_nxt[k];
            end

            if (valid_in || (r_ptr == 2'd0) || w_fire) begin
                r_idle <= 8'd0;
            end else begin
                r_idle <= r_idle + 8'd1;
            end

            r_vld     <= 4'd0;
            r_partial <= 1'b0;
            if (w_fire) begin
                for (int k = 0; k < 4; k++) begin
                    r_vld[k] <= (3'(k) < w_cnt);
                    r_dout[k] <= (3'(k) < w_cnt) ? w_slot_nxt[k] : '0;
                end
                r_partial <= (w_cnt != 3'd4);
                r_gcnt    <= r_gcnt + 8'd1;
            end
        end
    end

    assign valid_out0 = r_vld[0];
    assign valid_out1 = r_vld[1];
    assign valid_out2 = r_vld[2];
    assign valid_out3 = r_vld[3];
    assign data_out0  = r_dout[0];
    assign data_out1  = r_dout[1];
    assign data_out2  = r_dout[2];
    assign data_out3  = r_dout[3];
    assign partial    = r_partial;
    assign group_cnt  = r_gcnt;

endmodule
